// File: rtl/m_imem_loader_pkg.sv
// Shared types and constants for the UART instruction-memory loader.
// Loader and receiver state encodings live here so every user sees one definition.
package m_imem_loader_pkg;

   localparam int unsigned CLKS_PER_BIT_DEFAULT = 434;
   localparam int unsigned MAX_WORDS            = 4096;

   typedef enum logic [1:0] {
      LD_HDR,
      LD_LOAD,
      LD_DONE,
      LD_ERR
   } ld_state_t;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

   // A word count of zero or one larger than the memory cannot be loaded.
   function automatic logic hdr_bad(input logic [15:0] n);
      return (n == 16'd0) || (n > 16'(MAX_WORDS));
   endfunction

endpackage

// File: rtl/m_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, one-cycle byte/framing-error pulses.
module m_uart_rx
   import m_imem_loader_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
   input  logic       w_clk,
   input  logic       w_rst,
   input  logic       w_rxd,
   output logic       r_valid,
   output logic [7:0] r_byte,
   output logic       r_ferr
);

   localparam logic [15:0] FULL = 16'(CLKS_PER_BIT);
   localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2);

   logic        sync1_q, sync2_q, prev_q;
   rx_state_t   state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  shift_q, shift_d;
   logic        valid_q, valid_d;
   logic        ferr_q, ferr_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 16'd1;
      bit_d   = bit_q;
      shift_d = shift_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      case (state_q)
         RX_IDLE: begin
            cnt_d = 16'd1;
            if (prev_q && !sync2_q) state_d = RX_START;
         end
         RX_START: begin
            if (cnt_q == HALF) begin
               cnt_d = 16'd1;
               bit_d = '0;
               state_d = sync2_q ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (cnt_q == FULL) begin
               cnt_d   = 16'd1;
               shift_d = {sync2_q, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = RX_STOP;
            end
         end
         RX_STOP: begin
            if (cnt_q == FULL) begin
               state_d = RX_IDLE;
               valid_d = sync2_q;
               ferr_d  = !sync2_q;
            end
         end
         default: state_d = RX_IDLE;
      endcase
   end

   always_ff @(posedge w_clk or posedge w_rst) begin
      if (w_rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
         state_q <= RX_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         sync1_q <= w_rxd;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
      end
   end

   assign r_valid = valid_q;
   assign r_byte  = shift_q;
   assign r_ferr  = ferr_q;

endmodule

// File: rtl/m_imem_loader.sv
// Boot loader: receives a big-endian word count then that many big-endian words
// over UART and writes them to instruction memory while holding the core in reset.
module m_imem_loader
   import m_imem_loader_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
   input  logic        w_clk,
   input  logic        w_rst,
   input  logic        w_rxd,
   output logic        r_we,
   output logic [11:0] r_addr,
   output logic [31:0] r_data,
   output logic        r_busy,
   output logic        r_done,
   output logic        r_err
);

   logic       rx_valid;
   logic [7:0] rx_byte;
   logic       rx_ferr;

   m_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .w_clk   (w_clk),
      .w_rst   (w_rst),
      .w_rxd   (w_rxd),
      .r_valid (rx_valid),
      .r_byte  (rx_byte),
      .r_ferr  (rx_ferr)
   );

   ld_state_t   state_q, state_d;
   logic [1:0]  bcnt_q, bcnt_d;
   logic [7:0]  hdr_hi_q, hdr_hi_d;
   logic [11:0] last_addr_q, last_addr_d;
   logic [23:0] word_q, word_d;
   logic        last_q, last_d;
   logic        we_q, we_d;
   logic [11:0] addr_q, addr_d;
   logic [31:0] data_q, data_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic [15:0] hdr_n;

   always_comb begin
      state_d     = state_q;
      bcnt_d      = bcnt_q;
      hdr_hi_d    = hdr_hi_q;
      last_addr_d = last_addr_q;
      word_d      = word_q;
      last_d      = last_q;
      we_d        = 1'b0;
      addr_d      = addr_q;
      data_d      = data_q;
      busy_d      = busy_q;
      done_d      = done_q;
      err_d       = err_q;
      hdr_n       = {hdr_hi_q, rx_byte};
      case (state_q)
         LD_HDR: begin
            if (rx_ferr) begin
               state_d = LD_ERR;
               err_d   = 1'b1;
            end else if (rx_valid) begin
               if (bcnt_q == 2'd0) begin
                  hdr_hi_d = rx_byte;
                  bcnt_d   = 2'd1;
               end else begin
                  bcnt_d = '0;
                  if (hdr_bad(hdr_n)) begin
                     state_d = LD_ERR;
                     err_d   = 1'b1;
                  end else begin
                     state_d     = LD_LOAD;
                     last_addr_d = 12'(hdr_n - 16'd1);
                  end
               end
            end
         end
         LD_LOAD: begin
            // Address advances in the write cycle; the final write leaves it at N-1 instead of wrapping.
            if (we_q) begin
               if (last_q) begin
                  state_d = LD_DONE;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
               end else begin
                  addr_d = addr_q + 12'd1;
               end
            end else if (rx_ferr) begin
               state_d = LD_ERR;
               err_d   = 1'b1;
            end else if (rx_valid) begin
               bcnt_d = bcnt_q + 2'd1;
               if (bcnt_q == 2'd3) begin
                  we_d   = 1'b1;
                  data_d = {word_q, rx_byte};
                  last_d = (addr_q == last_addr_q);
               end else begin
                  word_d = {word_q[15:0], rx_byte};
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge w_clk or posedge w_rst) begin
      if (w_rst) begin
         state_q     <= LD_HDR;
         bcnt_q      <= '0;
         hdr_hi_q    <= '0;
         last_addr_q <= '0;
         word_q      <= '0;
         last_q      <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         data_q      <= '0;
         busy_q      <= 1'b1;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         bcnt_q      <= bcnt_d;
         hdr_hi_q    <= hdr_hi_d;
         last_addr_q <= last_addr_d;
         word_q      <= word_d;
         last_q      <= last_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign r_we   = we_q;
   assign r_addr = addr_q;
   assign r_data = data_q;
   assign r_busy = busy_q;
   assign r_done = done_q;
   assign r_err  = err_q;

endmodule

// File: tb/tb_m_imem_loader.sv
// Scoreboard bench for m_imem_loader: directed UART streams, expected writes queued
// by the stimulus and popped by a monitor on every r_we.
module tb_m_imem_loader;

   localparam int unsigned CPB = 4;

   logic        w_clk = 1'b0;
   logic        w_rst = 1'b1;
   logic        w_rxd = 1'b1;
   logic        r_we;
   logic [11:0] r_addr;
   logic [31:0] r_data;
   logic        r_busy;
   logic        r_done;
   logic        r_err;

   m_imem_loader #(.CLKS_PER_BIT(CPB)) dut (
      .w_clk  (w_clk),
      .w_rst  (w_rst),
      .w_rxd  (w_rxd),
      .r_we   (r_we),
      .r_addr (r_addr),
      .r_data (r_data),
      .r_busy (r_busy),
      .r_done (r_done),
      .r_err  (r_err)
   );

   always #5 w_clk = ~w_clk;

   typedef struct packed {
      logic [11:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t         exp_q[$];
   wr_t         mon_e;
   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge w_clk) begin
      if (w_rst === 1'b0 && r_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_we: got write addr %h data %h, expected no write", r_addr, r_data);
         end else begin
            mon_e = exp_q.pop_front();
            check("we_addr", 32'(r_addr), 32'(mon_e.addr));
            check("we_data", r_data, mon_e.data);
         end
      end
   end

   task automatic hold_bit(input logic v);
      w_rxd = v;
      repeat (CPB) @(posedge w_clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
      hold_bit(1'b0);
      for (int i = 0; i < 8; i++) hold_bit(b[i]);
      hold_bit(stop);
      hold_bit(1'b1);
      hold_bit(1'b1);
   endtask

   task automatic send_word(input logic [31:0] w, input logic [11:0] a);
      wr_t e;
      e.addr = a;
      e.data = w;
      exp_q.push_back(e);
      send_byte(w[31:24]);
      send_byte(w[23:16]);
      send_byte(w[15:8]);
      send_byte(w[7:0]);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_we"},   32'(r_we),   32'd0);
      check({tag, "_addr"}, 32'(r_addr), 32'd0);
      check({tag, "_data"}, r_data,      32'd0);
      check({tag, "_busy"}, 32'(r_busy), 32'd1);
      check({tag, "_done"}, 32'(r_done), 32'd0);
      check({tag, "_err"},  32'(r_err),  32'd0);
   endtask

   task automatic apply_reset();
      w_rst = 1'b1;
      w_rxd = 1'b1;
      repeat (3) @(posedge w_clk);
      #1;
      exp_q.delete();
      w_rst = 1'b0;
      repeat (2) @(posedge w_clk);
      #1;
   endtask

   task automatic check_status(input string tag, input logic done, input logic busy, input logic err);
      repeat (6) @(posedge w_clk);
      #1;
      check({tag, "_done"},    32'(r_done),       32'(done));
      check({tag, "_busy"},    32'(r_busy),       32'(busy));
      check({tag, "_err"},     32'(r_err),        32'(err));
      check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected end of stimulus");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset values
      w_rst = 1'b1;
      repeat (3) @(posedge w_clk);
      #1;
      check_reset_outputs("reset");
      apply_reset();

      // Single word load
      send_byte(8'h00);
      send_byte(8'h01);
      send_word(32'h2014000B, 12'd0);
      check_status("one_word", 1'b1, 1'b0, 1'b0);

      // Three words, then trailing byte and a framing error are ignored in DONE
      apply_reset();
      send_byte(8'h00);
      send_byte(8'h03);
      send_word(32'h11223344, 12'd0);
      send_word(32'hA5A55A5A, 12'd1);
      send_word(32'hDEADBEEF, 12'd2);
      check_status("three_words", 1'b1, 1'b0, 1'b0);
      send_byte(8'h77);
      send_byte(8'h55, 1'b0);
      check_status("done_ignore", 1'b1, 1'b0, 1'b0);

      // Zero word count
      apply_reset();
      send_byte(8'h00);
      send_byte(8'h00);
      check_status("hdr_zero", 1'b0, 1'b1, 1'b1);
      send_byte(8'h01);
      send_byte(8'h02);
      send_byte(8'h03);
      send_byte(8'h04);
      check_status("err_sticky", 1'b0, 1'b1, 1'b1);

      // Count 4097 is too large
      apply_reset();
      send_byte(8'h10);
      send_byte(8'h01);
      check_status("hdr_4097", 1'b0, 1'b1, 1'b1);

      // Count 4096 is accepted
      apply_reset();
      send_byte(8'h10);
      send_byte(8'h00);
      check_status("hdr_4096", 1'b0, 1'b1, 1'b0);
      send_word(32'h0BADF00D, 12'd0);
      check_status("hdr_4096_w0", 1'b0, 1'b1, 1'b0);

      // Framing error on third byte of word 0
      apply_reset();
      send_byte(8'h00);
      send_byte(8'h02);
      send_byte(8'h01);
      send_byte(8'h02);
      send_byte(8'h03, 1'b0);
      check_status("ferr_load", 1'b0, 1'b1, 1'b1);
      send_byte(8'h04);
      send_byte(8'h05);
      send_byte(8'h06);
      send_byte(8'h07);
      send_byte(8'h08);
      check_status("ferr_sticky", 1'b0, 1'b1, 1'b1);

      // One-cycle glitch on idle line, then a good load
      apply_reset();
      w_rxd = 1'b0;
      @(posedge w_clk);
      #1;
      w_rxd = 1'b1;
      repeat (20) @(posedge w_clk);
      #1;
      check_status("glitch", 1'b0, 1'b1, 1'b0);
      send_byte(8'h00);
      send_byte(8'h02);
      send_word(32'h01234567, 12'd0);
      send_word(32'h89ABCDEF, 12'd1);
      check_status("after_glitch", 1'b1, 1'b0, 1'b0);

      // Reset mid-word and mid-byte, then a fresh load
      apply_reset();
      send_byte(8'h00);
      send_byte(8'h02);
      send_word(32'hCAFEF00D, 12'd0);
      send_byte(8'h12);
      send_byte(8'h34);
      w_rxd = 1'b0;
      repeat (6) @(posedge w_clk);
      #1;
      w_rst = 1'b1;
      #1;
      check_reset_outputs("async_rst");
      repeat (2) @(posedge w_clk);
      #1;
      w_rxd = 1'b1;
      exp_q.delete();
      w_rst = 1'b0;
      repeat (4) @(posedge w_clk);
      #1;
      send_byte(8'h00);
      send_byte(8'h02);
      send_word(32'h5A5A0001, 12'd0);
      send_word(32'hF0E1D2C3, 12'd1);
      check_status("reload", 1'b1, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
